// File: rtl/i2s_frame_ctrl_if.sv
// Frame-sequencer bus: run request in, bit/word clocks and shifter strobes out.
// master = i2s_frame_ctrl, slave = shifter / system side.
interface i2s_frame_ctrl_if;
  logic en;
  logic sclk;
  logic lrck;
  logic tx_load;
  logic tx_shift;
  logic rx_sample;
  logic rx_done;
  logic rx_ch;
  logic active;
  logic mute;

  modport master (
    input  en,
    output sclk, lrck, tx_load, tx_shift, rx_sample, rx_done, rx_ch, active, mute
  );

  modport slave (
    output en,
    input  sclk, lrck, tx_load, tx_shift, rx_sample, rx_done, rx_ch, active, mute
  );
endinterface

// File: rtl/i2s_frame_ctrl.sv
// I2S frame sequencer, clocked by mclk.
// Generates sclk/lrck and per-bit strobes for the serializer/deserializer,
// with frame-aligned start and drain-to-frame-end stop.
// Optional startup mute: define I2S_MUTE_EN (adds MUTE_FRAMES parameter).
module i2s_frame_ctrl #(
  parameter int unsigned MCLK_PER_SCLK = 4,
  parameter int unsigned SLOTS_PER_CH  = 32,
  parameter int unsigned DATA_WIDTH    = 24
`ifdef I2S_MUTE_EN
  ,
  parameter int unsigned MUTE_FRAMES   = 256
`endif
) (
  input logic              mclk,
  input logic              rst,
  i2s_frame_ctrl_if.master bus
);

  localparam int unsigned HALF   = MCLK_PER_SCLK / 2;
  localparam int unsigned DIV_W  = (MCLK_PER_SCLK > 2) ? $clog2(MCLK_PER_SCLK) : 1;
  localparam int unsigned SLOT_W = (SLOTS_PER_CH > 2) ? $clog2(SLOTS_PER_CH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [SLOT_W-1:0]  slot;
  logic               sclk_r;
  logic               lrck_r;
  logic               tx_load_r;
  logic               tx_shift_r;
  logic               rx_sample_r;
  logic               rx_done_r;
  logic               rx_ch_r;
  logic               active_r;

  logic               div_last;
  logic               div_mid;
  logic               slot_last;
  logic               frame_end;
  logic               stopping;
  logic [DIV_W-1:0]   div_next;
  logic [SLOT_W-1:0]  slot_next;
  logic               data_slot;
  logic               data_slot_next;

  // Next-phase decode; strobes are registered against the phase they open.
  always_comb begin
    div_last       = (div_cnt == DIV_W'(MCLK_PER_SCLK - 1));
    div_mid        = (div_cnt == DIV_W'(HALF - 1));
    slot_last      = (slot == SLOT_W'(SLOTS_PER_CH - 1));
    frame_end      = div_last && slot_last && lrck_r;
    stopping       = (state == DRAIN) && !bus.en && frame_end;
    div_next       = div_last ? '0 : div_cnt + 1'b1;
    slot_next      = slot;
    if (div_last)
      slot_next    = slot_last ? '0 : slot + 1'b1;
    data_slot      = (slot != '0) && (slot <= SLOT_W'(DATA_WIDTH));
    data_slot_next = (slot_next != '0) && (slot_next <= SLOT_W'(DATA_WIDTH));
  end

  // Sequencer FSM with counters and registered clock/strobe outputs.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      div_cnt     <= '0;
      slot        <= '0;
      sclk_r      <= 1'b0;
      lrck_r      <= 1'b0;
      tx_load_r   <= 1'b0;
      tx_shift_r  <= 1'b0;
      rx_sample_r <= 1'b0;
      rx_done_r   <= 1'b0;
      rx_ch_r     <= 1'b0;
      active_r    <= 1'b0;
    end else begin
      tx_load_r   <= 1'b0;
      tx_shift_r  <= 1'b0;
      rx_sample_r <= 1'b0;
      rx_done_r   <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt <= '0;
          slot    <= '0;
          sclk_r  <= 1'b0;
          lrck_r  <= 1'b0;
          if (bus.en) begin
            state     <= RUN;
            active_r  <= 1'b1;
            tx_load_r <= 1'b1;
          end
        end
        RUN, DRAIN: begin
          if (stopping) begin
            // The edge that would open the next left slot 0 lands in IDLE instead.
            state    <= IDLE;
            active_r <= 1'b0;
            div_cnt  <= '0;
            slot     <= '0;
            sclk_r   <= 1'b0;
            lrck_r   <= 1'b0;
          end else begin
            state       <= bus.en ? RUN : DRAIN;
            div_cnt     <= div_next;
            slot        <= slot_next;
            sclk_r      <= (div_next >= DIV_W'(HALF));
            if (div_last && slot_last)
              lrck_r    <= ~lrck_r;
            tx_load_r   <= div_last && (slot_next == '0);
            tx_shift_r  <= div_last && data_slot_next;
            rx_sample_r <= div_mid && data_slot;
            if (rx_sample_r && (slot == SLOT_W'(DATA_WIDTH))) begin
              rx_done_r <= 1'b1;
              rx_ch_r   <= lrck_r;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef I2S_MUTE_EN
  localparam int unsigned MUTE_W = (MUTE_FRAMES > 1) ? $clog2(MUTE_FRAMES) : 1;

  logic              mute_r;
  logic [MUTE_W-1:0] mute_cnt;

  // Startup mute: armed on IDLE->RUN, released on the tx_load opening frame MUTE_FRAMES+1.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      mute_r   <= 1'b0;
      mute_cnt <= '0;
    end else if (state == IDLE) begin
      mute_r   <= bus.en;
      mute_cnt <= '0;
    end else if (stopping) begin
      mute_r   <= 1'b0;
      mute_cnt <= '0;
    end else if (frame_end && mute_r) begin
      if (mute_cnt == MUTE_W'(MUTE_FRAMES - 1))
        mute_r   <= 1'b0;
      else
        mute_cnt <= mute_cnt + 1'b1;
    end
  end

  assign bus.mute = mute_r;
`else
  assign bus.mute = 1'b0;
`endif

  assign bus.sclk      = sclk_r;
  assign bus.lrck      = lrck_r;
  assign bus.tx_load   = tx_load_r;
  assign bus.tx_shift  = tx_shift_r;
  assign bus.rx_sample = rx_sample_r;
  assign bus.rx_done   = rx_done_r;
  assign bus.rx_ch     = rx_ch_r;
  assign bus.active    = active_r;

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Directed bench for i2s_frame_ctrl at default geometry (4 mclk/sclk, 32 slots, 24 bits).
// With I2S_MUTE_EN defined the DUT is built with MUTE_FRAMES=4.
module tb_i2s_frame_ctrl;

  localparam int unsigned NEVER = 32'hFFFF_FFFF;
`ifdef I2S_MUTE_EN
  localparam int unsigned MF = 4;
`endif

  logic mclk;
  logic rst;

  int total;
  int bad;

  int unsigned n_load[2];
  int unsigned n_shift[2];
  int unsigned n_samp[2];
  int unsigned n_done[2];

  logic        sdi;
  logic [23:0] word;
  logic [23:0] shreg;
  int unsigned bitcnt;

  i2s_frame_ctrl_if bus_if ();

`ifdef I2S_MUTE_EN
  i2s_frame_ctrl #(
    .MCLK_PER_SCLK (4),
    .SLOTS_PER_CH  (32),
    .DATA_WIDTH    (24),
    .MUTE_FRAMES   (MF)
  ) dut (
    .mclk (mclk),
    .rst  (rst),
    .bus  (bus_if)
  );
`else
  i2s_frame_ctrl #(
    .MCLK_PER_SCLK (4),
    .SLOTS_PER_CH  (32),
    .DATA_WIDTH    (24)
  ) dut (
    .mclk (mclk),
    .rst  (rst),
    .bus  (bus_if)
  );
`endif

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {active, mute, sclk, lrck, tx_load, tx_shift, rx_sample, rx_done}
  // k mclk cycles after the IDLE->RUN edge; all zero from end_k on.
  function automatic logic [7:0] model(input int unsigned k, input int unsigned end_k);
    int unsigned div;
    int unsigned sl;
    int unsigned lr;
    logic        m;
    if (k >= end_k) return 8'h00;
    div = k % 4;
    sl  = (k / 4) % 32;
    lr  = (k / 128) % 2;
`ifdef I2S_MUTE_EN
    m = (k < MF * 256);
`else
    m = 1'b0;
`endif
    return {1'b1, m, (div >= 2), lr[0],
            (div == 0 && sl == 0),
            (div == 0 && sl >= 1 && sl <= 24),
            (div == 2 && sl >= 1 && sl <= 24),
            (div == 3 && sl == 24)};
  endfunction

  function automatic logic [7:0] obs_vec();
    return {bus_if.active, bus_if.mute, bus_if.sclk, bus_if.lrck,
            bus_if.tx_load, bus_if.tx_shift, bus_if.rx_sample, bus_if.rx_done};
  endfunction

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      n_load[i]  = 0;
      n_shift[i] = 0;
      n_samp[i]  = 0;
      n_done[i]  = 0;
    end
  endtask

  // Check cycles from_k..to_k-1 against the model; loopback shifter drives sdi
  // from the 0xA5A5A5/0x5A5A5A words and captures it on rx_sample.
  task automatic run_seg(input int unsigned from_k, input int unsigned to_k, input int unsigned end_k);
    logic [7:0] exp_v;
    logic [7:0] obs_v;
    int         ch;
    for (int unsigned k = from_k; k < to_k; k++) begin
      exp_v = model(k, end_k);
      obs_v = obs_vec();
      check($sformatf("cycle k=%0d", k), {24'h0, obs_v}, {24'h0, exp_v});
      ch = bus_if.lrck ? 1 : 0;
      if (bus_if.tx_load)   n_load[ch]++;
      if (bus_if.tx_shift)  n_shift[ch]++;
      if (bus_if.rx_sample) n_samp[ch]++;
      if (bus_if.rx_done)   n_done[ch]++;
      if (exp_v[3]) begin
        bitcnt = 0;
        word   = exp_v[4] ? 24'h5A5A5A : 24'hA5A5A5;
      end
      if (exp_v[2] && bitcnt < 24) begin
        sdi = word[23 - bitcnt];
        bitcnt++;
      end
      if (bus_if.rx_sample) shreg = {shreg[22:0], sdi};
      if (exp_v[0]) begin
        check($sformatf("rx_ch k=%0d", k), {31'h0, bus_if.rx_ch}, {31'h0, exp_v[4]});
        check($sformatf("rx_word k=%0d", k), {8'h0, shreg},
              exp_v[4] ? 32'h005A5A5A : 32'h00A5A5A5);
      end
      step();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    sdi   = 1'b0;
    word  = '0;
    shreg = '0;
    bitcnt = 0;
    clear_counts();
    rst       = 1'b1;
    bus_if.en = 1'b0;

    // Reset held, then released with en=0: everything stays quiet.
    repeat (5) step();
    check("reset_outputs", {23'h0, obs_vec(), bus_if.rx_ch}, 32'h0);
    rst = 1'b0;
    run_seg(0, 1000, 0);
    check("idle_active", {31'h0, bus_if.active}, 32'h0);

    // Free run; strobe census over frame 1; stop mid-left (slot 10) of frame 5.
    bus_if.en = 1'b1;
    step();
    run_seg(0, 256, NEVER);
    clear_counts();
    run_seg(256, 512, NEVER);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("n_load ch%0d", c),  n_load[c],  32'd1);
      check($sformatf("n_shift ch%0d", c), n_shift[c], 32'd24);
      check($sformatf("n_samp ch%0d", c),  n_samp[c],  32'd24);
      check($sformatf("n_done ch%0d", c),  n_done[c],  32'd1);
    end
    run_seg(512, 1320, NEVER);
    bus_if.en = 1'b0;
    clear_counts();
    run_seg(1320, 1600, 1536);
    check("drain_right_done", n_done[1], 32'd1);
    check("drain_right_load", n_load[1], 32'd1);
    check("drain_no_left_load", n_load[0], 32'd0);
    check("stopped_sclk", {31'h0, bus_if.sclk}, 32'h0);
    check("stopped_lrck", {31'h0, bus_if.lrck}, 32'h0);

    // Drop en at slot 10 left, re-raise in DRAIN: phase continues undisturbed.
    bus_if.en = 1'b1;
    step();
    run_seg(0, 296, NEVER);
    bus_if.en = 1'b0;
    run_seg(296, 400, NEVER);
    bus_if.en = 1'b1;
    run_seg(400, 1064, NEVER);
    bus_if.en = 1'b0;
    run_seg(1064, 1400, 1280);

    // One-cycle en pulse in IDLE: one full frame, then IDLE.
    bus_if.en = 1'b1;
    step();
    bus_if.en = 1'b0;
    run_seg(0, 300, 256);

    // Reset at slot 15 of the right channel with en held high.
    bus_if.en = 1'b1;
    step();
    run_seg(0, 188, NEVER);
    rst = 1'b1;
    #1;
    check("rst_async", {23'h0, obs_vec(), bus_if.rx_ch}, 32'h0);
    @(posedge mclk);
    #1;
    check("rst_held", {24'h0, obs_vec()}, 32'h0);
    rst = 1'b0;
    step();
    run_seg(0, 300, NEVER);
    bus_if.en = 1'b0;
    run_seg(300, 600, 512);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
